plab5_mcore_mem_sec_tracker: RTL
================================

PLAB5_MCORE_MEM_SEC_TRACKER -- requirements
Module: plab5_mcore_mem_sec_tracker

Purpose: sits downstream of the memory access controller on the response path. It tracks the security level of every outstanding memory request in order, so response labelling does not depend on a fixed-latency delay.

Interface
REQ-001 SHALL have parameter p_opaque_nbits, default 8: width of the opaque field of memory messages.
REQ-002 SHALL have parameter p_depth, default 4: maximum number of outstanding requests; SHALL be a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_val, input, 1 bit: a network request is valid at the controller input.
REQ-006 SHALL have port req_rdy_in, input, 1 bit: the controller's ready toward the network.
REQ-007 SHALL have port req_rdy, output, 1 bit: ready presented to the network; equals req_rdy_in AND NOT full.
REQ-008 SHALL have port req_sec_level, input, 1 bit: security level of the current request.
REQ-009 SHALL have port mem_sec_level, input, 1 bit: the memory's security level.
REQ-010 SHALL have port req_opaque, input, p_opaque_nbits: opaque field of the current request.
REQ-011 SHALL have port resp_val, input, 1 bit: the controller's response valid.
REQ-012 SHALL have port resp_rdy, input, 1 bit: the network's response ready.
REQ-013 SHALL have port resp_opaque, input, p_opaque_nbits: opaque field of the current response.
REQ-014 SHALL have port resp_sec_level, output, 1 bit: security level of the oldest outstanding request.
REQ-015 SHALL have port resp_sec_val, output, 1 bit: resp_sec_level is meaningful (FIFO not empty).
REQ-016 SHALL have port outstanding, output, clog2(p_depth)+1 bits: current occupancy.
REQ-017 SHALL have port viol_count, output, 16 bits: saturating count of accepted insecure requests.
REQ-018 SHALL have port order_err, output, 1 bit: sticky flag for a response opaque mismatch or a response while empty.

Function
REQ-019 SHALL define push as req_val AND req_rdy, both sampled at the rising edge.
REQ-020 SHALL define pop as resp_val AND resp_rdy AND NOT empty, sampled at the rising edge.
REQ-021 SHALL, on push, write {req_sec_level, req_opaque} at the write pointer and advance the write pointer modulo p_depth.
REQ-022 SHALL, on pop, advance the read pointer modulo p_depth.
REQ-023 SHALL maintain occupancy as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-024 SHALL allow simultaneous push and pop when full: req_rdy is still low when full, so no push can occur.
REQ-025 SHALL allow simultaneous push and pop when empty: pop is suppressed, so only the push takes effect.
REQ-026 SHALL drive full combinationally as occupancy == p_depth, and empty as occupancy == 0.
REQ-027 SHALL drive resp_sec_level combinationally from the head entry when not empty, and drive 0 when empty (no X).
REQ-028 SHALL give resp_sec_val a latency of zero: it rises in the same cycle as the first push's following edge, i.e. as soon as occupancy becomes 1.
REQ-029 SHALL make a newly pushed entry visible at the head in the cycle after the push edge; there SHALL be no bypass.
REQ-030 SHALL increment viol_count by 1 on each push with req_sec_level==0 and mem_sec_level==1, and SHALL saturate it at 16'hFFFF.
REQ-031 SHALL set order_err on any pop where resp_opaque differs from the head opaque.
REQ-032 SHALL set order_err on any edge with resp_val AND resp_rdy while empty.
REQ-033 SHALL keep order_err set until reset once it is set.
REQ-034 SHALL still perform a pop on an opaque mismatch; ordering is not repaired.
REQ-035 SHALL control occupancy with an implicit two-state machine (EMPTY/ACTIVE): EMPTY->ACTIVE on push; ACTIVE->EMPTY on a pop without push at occupancy 1.

Reset
REQ-036 SHALL, on reset low, immediately and asynchronously clear pointers, occupancy, viol_count and order_err.
REQ-037 SHALL therefore drive these outputs while reset is asserted: outstanding=0, resp_sec_val=0, resp_sec_level=0, req_rdy=req_rdy_in.
REQ-038 SHALL discard all outstanding entries on a reset mid-operation; FIFO storage contents need not be cleared.
REQ-039 SHALL ignore push and pop while reset is low.

Verification
REQ-040 SHALL cover in-order labelling: push levels 1,0,1 with opaque 5,6,7; then pop three with matching opaques -> resp_sec_level 1,0,1 in order; outstanding 3->0; order_err=0.
REQ-041 SHALL cover full back-pressure: with p_depth=4, push 4 with req_rdy_in=1 -> outstanding=4, req_rdy=0; a fifth req_val is not accepted; pop 1 -> req_rdy=1 in the same cycle.
REQ-042 SHALL cover simultaneous push and pop: at occupancy 2, push and pop on the same edge -> occupancy stays 2; the head advances to the second entry.
REQ-043 SHALL cover violation counting and saturation: mem_sec_level=1, push 3 requests with level 0 and 1 with level 1 -> viol_count=3; force viol_count to FFFF and push level 0 -> it stays FFFF.
REQ-044 SHALL cover order errors: pop with resp_opaque=9 while the head opaque is 5 -> order_err=1 and the pop still occurs; a separate test with resp_val&resp_rdy while empty -> order_err=1 and occupancy stays 0.
REQ-045 SHALL cover reset mid-operation: with occupancy 3 and viol_count 2, drop reset between clock edges -> outstanding=0, viol_count=0, resp_sec_val=0 without waiting for a clock edge.

Source files
------------

// File: rtl/plab5_mcore_mem_sec_tracker.sv
// ---------------------------------------------------------------------------
// plab5_mcore_mem_sec_tracker
//
// Sits on the response path just downstream of the memory access controller.
// Every request accepted from the network has its security level and opaque
// tag recorded in an in-order FIFO. The oldest entry labels the response that
// is currently leaving the controller, so labelling stays correct whatever the
// memory latency turns out to be.
//
// Parameters
//   p_opaque_nbits : width of the opaque field of memory messages
//   p_depth        : maximum outstanding requests (power of two, >= 2)
//
// Ports
//   clk            : single clock, rising-edge active
//   reset          : asynchronous, active-low reset
//   req_val        : network request valid at the controller input
//   req_rdy_in     : controller ready toward the network
//   req_rdy        : ready presented to the network (req_rdy_in and not full)
//   req_sec_level  : security level of the current request
//   mem_sec_level  : security level of the memory behind the controller
//   req_opaque     : opaque field of the current request
//   resp_val       : controller response valid
//   resp_rdy       : network response ready
//   resp_opaque    : opaque field of the current response
//   resp_sec_level : security level of the oldest outstanding request
//   resp_sec_val   : resp_sec_level is meaningful (tracker not empty)
//   outstanding    : current number of tracked requests
//   viol_count     : saturating count of accepted insecure requests
//   order_err      : sticky flag for an opaque mismatch or a response while empty
// ---------------------------------------------------------------------------
module plab5_mcore_mem_sec_tracker #(
   parameter int p_opaque_nbits = 8,
   parameter int p_depth        = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_val,
   input  logic                        req_rdy_in,
   output logic                        req_rdy,
   input  logic                        req_sec_level,
   input  logic                        mem_sec_level,
   input  logic [p_opaque_nbits-1:0]   req_opaque,
   input  logic                        resp_val,
   input  logic                        resp_rdy,
   input  logic [p_opaque_nbits-1:0]   resp_opaque,
   output logic                        resp_sec_level,
   output logic                        resp_sec_val,
   output logic [$clog2(p_depth):0]    outstanding,
   output logic [15:0]                 viol_count,
   output logic                        order_err
);

   localparam int ptr_w = $clog2(p_depth);
   localparam logic [ptr_w-1:0] ptr_one = ptr_w'(1);
   localparam logic [ptr_w:0]   cnt_one = (ptr_w + 1)'(1);
   localparam logic [ptr_w:0]   cnt_max = (ptr_w + 1)'(p_depth);

   typedef enum logic {
      EMPTY,
      ACTIVE
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic [ptr_w-1:0]         wr_ptr_q;
   logic [ptr_w-1:0]         rd_ptr_q;
   logic [ptr_w:0]           count_q;
   logic [ptr_w:0]           count_d;
   logic [15:0]              viol_count_q;
   logic                     order_err_q;
   logic [p_opaque_nbits:0]  store [p_depth];

   logic                        full;
   logic                        empty;
   logic                        push;
   logic                        pop;
   logic [p_opaque_nbits:0]     head;
   logic [p_opaque_nbits-1:0]   head_opaque;
   logic                        resp_fire;

   // Occupancy flags and handshakes. Push and pop are gated by reset so that
   // nothing, including the storage write, happens while reset is held low.
   assign full        = (count_q == cnt_max);
   assign empty       = (count_q == '0);
   assign req_rdy     = req_rdy_in & ~full;
   assign push        = req_val & req_rdy & reset;
   assign resp_fire   = resp_val & resp_rdy & reset;
   assign pop         = resp_fire & ~empty;
   assign head        = store[rd_ptr_q];
   assign head_opaque = head[p_opaque_nbits-1:0];

   // The head label is forced to 0 while empty so stale storage never leaks
   // out as an X or an old level.
   assign resp_sec_level = empty ? 1'b0 : head[p_opaque_nbits];
   assign resp_sec_val   = ~empty;
   assign outstanding    = count_q;
   assign viol_count     = viol_count_q;
   assign order_err      = order_err_q;

   // Entry storage is never reset; discarded entries are simply unreachable
   // once the pointers are cleared. A push is written at the tail and only
   // becomes visible at the head after this edge (no bypass).
   always_ff @(posedge clk) begin
      if (push) begin
         store[wr_ptr_q] <= {req_sec_level, req_opaque};
      end
   end

   // Occupancy state machine. EMPTY can only see a push because pop is
   // suppressed while empty; in ACTIVE a simultaneous push and pop leaves the
   // count alone, and the last pop without a push returns to EMPTY.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = ACTIVE;
               count_d = cnt_one;
            end
         end
         ACTIVE: begin
            if (push && !pop) begin
               count_d = count_q + cnt_one;
            end else if (pop && !push) begin
               count_d = count_q - cnt_one;
               if (count_q == cnt_one) begin
                  state_d = EMPTY;
               end
            end
         end
         default: begin
            state_d = EMPTY;
            count_d = '0;
         end
      endcase
   end

   // State, pointers and occupancy. Pointers wrap naturally because the depth
   // is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= EMPTY;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + ptr_one;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + ptr_one;
         end
      end
   end

   // Violation counter: an insecure request reaching secure memory. It sticks
   // at all-ones rather than wrapping so a long run cannot look clean.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         viol_count_q <= '0;
      end else if (push && !req_sec_level && mem_sec_level &&
                   (viol_count_q != 16'hFFFF)) begin
         viol_count_q <= viol_count_q + 16'd1;
      end
   end

   // Ordering error: the response tag does not match the oldest request, or a
   // response arrives with nothing outstanding. The pop still happens on a
   // mismatch; the flag only records that labelling can no longer be trusted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         order_err_q <= 1'b0;
      end else if ((resp_fire && empty) ||
                   (pop && (resp_opaque != head_opaque))) begin
         order_err_q <= 1'b1;
      end
   end

endmodule
